// File: rtl/mem_dual_lat.sv
// Dual-port word memory with an instruction read port and a data read/write port,
// each read port returning responses after a fixed pipeline latency.

module mem_dual_lat_rd_pipe #(
    parameter int LAT        = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_data
);
    logic [LAT-1:0]        stage_valid;
    logic [LAT-1:0]        stage_err;
    logic [DATA_WIDTH-1:0] stage_data [LAT];

    // Data only advances with a valid entry so the last stage holds the previous response.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            stage_valid <= '0;
            stage_err   <= '0;
            for (int i = 0; i < LAT; i++) stage_data[i] <= '0;
        end else begin
            stage_valid[0] <= in_valid;
            stage_err[0]   <= in_valid & in_err;
            if (in_valid) stage_data[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_err[i]   <= stage_err[i-1];
                if (stage_valid[i-1]) stage_data[i] <= stage_data[i-1];
            end
        end
    end

    assign resp_valid = stage_valid[LAT-1];
    assign resp_err   = stage_err[LAT-1];
    assign resp_data  = stage_data[LAT-1];
endmodule

module mem_dual_lat #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 14,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    INST_LAT   = 1,
    parameter int                    DATA_LAT   = 2
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    pMemInst_pRd_bValid,
    output logic                    pMemInst_pRd_bReady,
    input  logic [ADDR_WIDTH-1:0]   pMemInst_pRd_bAddr,
    output logic                    pMemInst_pRd_bRespValid,
    output logic [DATA_WIDTH-1:0]   pMemInst_pRd_bData,
    output logic                    pMemInst_pRd_bErr,
    input  logic                    pMemData_pRd_bValid,
    output logic                    pMemData_pRd_bReady,
    input  logic [ADDR_WIDTH-1:0]   pMemData_pRd_bAddr,
    output logic                    pMemData_pRd_bRespValid,
    output logic [DATA_WIDTH-1:0]   pMemData_pRd_bData,
    output logic                    pMemData_pRd_bErr,
    input  logic                    pMemData_pWr_bValid,
    output logic                    pMemData_pWr_bReady,
    input  logic [ADDR_WIDTH-1:0]   pMemData_pWr_bAddr,
    input  logic [DATA_WIDTH-1:0]   pMemData_pWr_bData,
    input  logic [DATA_WIDTH/8-1:0] pMemData_pWr_bMask,
    output logic                    pMemData_pWr_bAck,
    output logic                    pMemData_pWr_bErr
);
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int BSH     = $clog2(BYTES);
    localparam int IDX_TOP = DEPTH_LOG2 + BSH;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    logic [ADDR_WIDTH-1:0] ir_off, dr_off, wr_off;
    logic [DEPTH_LOG2-1:0] ir_idx, dr_idx, wr_idx;
    logic                  ir_oor, dr_oor, wr_oor;
    logic                  ir_acc, dr_acc, wr_acc, wr_hit_ok;
    logic [DATA_WIDTH-1:0] ir_word, dr_word;
    logic                  ack_pend, ack_pend_err;
    logic                  unused_off;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BYTES-1:0]      mask
    );
        logic [DATA_WIDTH-1:0] res;
        for (int b = 0; b < BYTES; b++)
            res[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        return res;
    endfunction

    assign pMemInst_pRd_bReady = ~iReset;
    assign pMemData_pRd_bReady = ~iReset;
    assign pMemData_pWr_bReady = ~iReset;

    assign ir_acc = pMemInst_pRd_bValid & pMemInst_pRd_bReady;
    assign dr_acc = pMemData_pRd_bValid & pMemData_pRd_bReady;
    assign wr_acc = pMemData_pWr_bValid & pMemData_pWr_bReady;

    // Subtraction wraps, so addresses below the base also land out of range.
    assign ir_off = pMemInst_pRd_bAddr - BASE_ADDR;
    assign dr_off = pMemData_pRd_bAddr - BASE_ADDR;
    assign wr_off = pMemData_pWr_bAddr - BASE_ADDR;
    assign ir_oor = |ir_off[ADDR_WIDTH-1:IDX_TOP];
    assign dr_oor = |dr_off[ADDR_WIDTH-1:IDX_TOP];
    assign wr_oor = |wr_off[ADDR_WIDTH-1:IDX_TOP];
    assign ir_idx = ir_off[IDX_TOP-1:BSH];
    assign dr_idx = dr_off[IDX_TOP-1:BSH];
    assign wr_idx = wr_off[IDX_TOP-1:BSH];
    assign unused_off = ^{ir_off, dr_off, wr_off};

    assign wr_hit_ok = wr_acc & ~wr_oor;

    // Write-first: a same-cycle write to the read index is forwarded into the read word.
    always_comb begin
        ir_word = '0;
        dr_word = '0;
        if (!ir_oor)
            ir_word = (wr_hit_ok && wr_idx == ir_idx)
                    ? merge_bytes(mem[ir_idx], pMemData_pWr_bData, pMemData_pWr_bMask)
                    : mem[ir_idx];
        if (!dr_oor)
            dr_word = (wr_hit_ok && wr_idx == dr_idx)
                    ? merge_bytes(mem[dr_idx], pMemData_pWr_bData, pMemData_pWr_bMask)
                    : mem[dr_idx];
    end

    always_ff @(posedge iClock) begin
        if (wr_hit_ok) begin
            for (int b = 0; b < BYTES; b++)
                if (pMemData_pWr_bMask[b]) mem[wr_idx][8*b +: 8] <= pMemData_pWr_bData[8*b +: 8];
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            ack_pend          <= 1'b0;
            ack_pend_err      <= 1'b0;
            pMemData_pWr_bAck <= 1'b0;
            pMemData_pWr_bErr <= 1'b0;
        end else begin
            ack_pend          <= wr_acc;
            ack_pend_err      <= wr_acc & wr_oor;
            pMemData_pWr_bAck <= ack_pend;
            pMemData_pWr_bErr <= ack_pend_err;
        end
    end

    mem_dual_lat_rd_pipe #(.LAT(INST_LAT), .DATA_WIDTH(DATA_WIDTH)) u_inst_pipe (
        .iClock     (iClock),
        .iReset     (iReset),
        .in_valid   (ir_acc),
        .in_err     (ir_oor),
        .in_data    (ir_word),
        .resp_valid (pMemInst_pRd_bRespValid),
        .resp_err   (pMemInst_pRd_bErr),
        .resp_data  (pMemInst_pRd_bData)
    );

    mem_dual_lat_rd_pipe #(.LAT(DATA_LAT), .DATA_WIDTH(DATA_WIDTH)) u_data_pipe (
        .iClock     (iClock),
        .iReset     (iReset),
        .in_valid   (dr_acc),
        .in_err     (dr_oor),
        .in_data    (dr_word),
        .resp_valid (pMemData_pRd_bRespValid),
        .resp_err   (pMemData_pRd_bErr),
        .resp_data  (pMemData_pRd_bData)
    );
endmodule

// File: tb/tb_mem_dual_lat.sv
// Scoreboard bench for mem_dual_lat: expected responses are queued with their due cycle
// when requests are driven and matched as the DUT produces them.

module tb_mem_dual_lat;
    localparam int          IL   = 1;
    localparam int          DLAT = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        ir_v = 0, dr_v = 0, wr_v = 0;
    logic [31:0] ir_a = 0, dr_a = 0, wr_a = 0, wr_d = 0;
    logic [3:0]  wr_m = 0;
    logic        ir_rdy, dr_rdy, wr_rdy, ir_rv, dr_rv, ir_err, dr_err, wr_ack, wr_err;
    logic [31:0] ir_d, dr_d;

    mem_dual_lat #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(14),
        .BASE_ADDR(BASE), .INST_LAT(IL), .DATA_LAT(DLAT)
    ) dut (
        .iClock                  (iClock),
        .iReset                  (iReset),
        .pMemInst_pRd_bValid     (ir_v),
        .pMemInst_pRd_bReady     (ir_rdy),
        .pMemInst_pRd_bAddr      (ir_a),
        .pMemInst_pRd_bRespValid (ir_rv),
        .pMemInst_pRd_bData      (ir_d),
        .pMemInst_pRd_bErr       (ir_err),
        .pMemData_pRd_bValid     (dr_v),
        .pMemData_pRd_bReady     (dr_rdy),
        .pMemData_pRd_bAddr      (dr_a),
        .pMemData_pRd_bRespValid (dr_rv),
        .pMemData_pRd_bData      (dr_d),
        .pMemData_pRd_bErr       (dr_err),
        .pMemData_pWr_bValid     (wr_v),
        .pMemData_pWr_bReady     (wr_rdy),
        .pMemData_pWr_bAddr      (wr_a),
        .pMemData_pWr_bData      (wr_d),
        .pMemData_pWr_bMask      (wr_m),
        .pMemData_pWr_bAck       (wr_ack),
        .pMemData_pWr_bErr       (wr_err)
    );

    always #5 iClock = ~iClock;

    int cyc = 0;
    always @(posedge iClock) cyc++;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sq [3][$];
    logic [31:0] last [3];
    string       pn [3] = '{"ir", "dr", "wr"};
    logic [31:0] model [int unsigned];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic oor(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off >= 32'h0001_0000;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a - BASE) >> 2;
    endfunction

    task automatic mon(input int p, input logic v, input logic [31:0] d, input logic e);
        exp_t x;
        if (sq[p].size() > 0 && sq[p][0].due < cyc) begin
            chk({pn[p], "_missed_due"}, cyc, sq[p][0].due);
            void'(sq[p].pop_front());
        end
        if (v === 1'b1) begin
            if (sq[p].size() == 0) begin
                chk({pn[p], "_spurious"}, v, 0);
            end else begin
                x = sq[p].pop_front();
                chk({pn[p], "_lat"}, cyc, x.due);
                chk({pn[p], "_err"}, e, x.err);
                if (p != 2) begin
                    chk({pn[p], "_data"}, d, x.data);
                    last[p] = x.data;
                end
            end
        end else begin
            chk({pn[p], "_valid_idle"}, v, 0);
            chk({pn[p], "_err_idle"}, e, 0);
            if (p != 2) chk({pn[p], "_hold"}, d, last[p]);
        end
    endtask

    always @(negedge iClock) begin
        if (cyc > 0) begin
            mon(0, ir_rv, ir_d, ir_err);
            mon(1, dr_rv, dr_d, dr_err);
            mon(2, wr_ack, 32'h0, wr_err);
        end
    end

    task automatic step(input logic irv, input logic [31:0] ira,
                        input logic drv, input logic [31:0] dra,
                        input logic wv, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] wm);
        exp_t        x;
        logic [31:0] w;
        ir_v = irv; ir_a = ira; dr_v = drv; dr_a = dra;
        wr_v = wv;  wr_a = wa;  wr_d = wd;  wr_m = wm;
        if (!iReset) begin
            if (wv) begin
                x.due = cyc + 2; x.err = oor(wa); x.data = 0;
                sq[2].push_back(x);
                if (!x.err) begin
                    w = model.exists(widx(wa)) ? model[widx(wa)] : 32'h0;
                    for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
                    model[widx(wa)] = w;
                end
            end
            if (irv) begin
                x.due = cyc + IL; x.err = oor(ira);
                x.data = x.err ? 32'h0 : model[widx(ira)];
                sq[0].push_back(x);
            end
            if (drv) begin
                x.due = cyc + DLAT; x.err = oor(dra);
                x.data = x.err ? 32'h0 : model[widx(dra)];
                sq[1].push_back(x);
            end
        end
        @(negedge iClock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush_for_reset();
        for (int p = 0; p < 3; p++) begin
            sq[p].delete();
            last[p] = 32'h0;
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++) last[p] = 32'h0;
        @(negedge iClock);
        #1;

        // Reset held with requests driven
        for (int i = 0; i < 3; i++) begin
            step(1, BASE, 1, BASE + 4, 1, BASE + 8, 32'h1111_1111, 4'hF);
            chk("rst_ir_ready", ir_rdy, 0);
            chk("rst_dr_ready", dr_rdy, 0);
            chk("rst_wr_ready", wr_rdy, 0);
            chk("rst_ir_data", ir_d, 0);
            chk("rst_dr_data", dr_d, 0);
        end
        iReset = 1'b0;
        ir_v = 0; dr_v = 0; wr_v = 0;
        #1;
        chk("rel_ir_ready", ir_rdy, 1);
        chk("rel_dr_ready", dr_rdy, 1);
        chk("rel_wr_ready", wr_rdy, 1);
        idle(3);

        // Byte-masked write and readback on both ports
        step(0, 0, 0, 0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111);
        step(0, 0, 0, 0, 1, BASE + 32'h10, 32'h0000_00AA, 4'b0001);
        step(1, BASE + 32'h10, 1, BASE + 32'h10, 0, 0, 0, 0);
        idle(3);

        // Write-first conflict on both read ports
        step(0, 0, 0, 0, 1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b1111);
        step(1, BASE + 32'h20, 1, BASE + 32'h20, 1, BASE + 32'h20, 32'h1234_5678, 4'b0011);
        step(1, BASE + 32'h20, 1, BASE + 32'h20, 0, 0, 0, 0);
        idle(3);

        // Streaming: fill 8 words then read them back to back
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 0, 1, BASE + 32'h40 + 4 * i, $urandom, 4'hF);
        for (int i = 0; i < 8; i++)
            step(1, BASE + 32'h40 + 4 * (7 - i), 1, BASE + 32'h40 + 4 * i, 0, 0, 0, 0);
        idle(4);

        // Range errors, mask-zero write, readback of last valid word
        step(1, BASE + 32'h0001_0000, 1, 32'h7FFF_FFFC, 1, BASE + 32'hFFFC, 32'hCAFE_F00D, 4'hF);
        step(0, 0, 0, 0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF);
        step(1, BASE + 32'hFFFC, 1, BASE + 32'hFFFC, 1, BASE + 32'h20, 32'h0, 4'b0000);
        step(0, 0, 1, BASE + 32'h20, 0, 0, 0, 0);
        idle(4);

        // Reset mid-flight: read and write in flight are dropped, write still lands
        step(0, 0, 1, BASE + 32'h10, 1, BASE + 32'h30, 32'h5A5A_5A5A, 4'hF);
        iReset = 1'b1;
        flush_for_reset();
        idle(1);
        iReset = 1'b0;
        idle(4);
        step(1, BASE + 32'h30, 1, BASE + 32'h30, 0, 0, 0, 0);
        idle(3);

        // Random traffic over the initialised window
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1), BASE + 32'h40 + 4 * $urandom_range(0, 7),
                 $urandom_range(0, 1), BASE + 32'h40 + 4 * $urandom_range(0, 7),
                 $urandom_range(0, 1), BASE + 32'h40 + 4 * $urandom_range(0, 7),
                 $urandom, 4'($urandom_range(0, 15)));

        for (int i = 0; i < 20; i++)
            if (sq[0].size() + sq[1].size() + sq[2].size() > 0) idle(1);
        for (int p = 0; p < 3; p++)
            chk({pn[p], "_drain"}, sq[p].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
